// File: rtl/p_int_div_pow2_pipe_if.sv
// Stream bundle for the divide-by-2^n stage: input beat with shift/mode,
// output beat with saturated quotients, remainders and overflow flags.
interface p_int_div_pow2_pipe_if #(
  parameter int LANES     = 4,
  parameter int I_PREC    = 16,
  parameter int O_PREC    = 8,
  parameter int MAX_SHIFT = 8
);
  localparam int SW = $clog2(MAX_SHIFT + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*I_PREC-1:0]    in_data;
  logic [SW-1:0]              in_shift;
  logic [1:0]                 in_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*O_PREC-1:0]    out_data;
  logic [LANES*MAX_SHIFT-1:0] out_rem;
  logic [LANES-1:0]           out_ovf;

  modport master (
    output in_valid, in_data, in_shift, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_rem, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_shift, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_rem, out_ovf
  );
endinterface

// File: rtl/p_int_div_pow2_pipe.sv
// Two-stage multi-lane divide-by-2^n with runtime rounding, remainder output,
// saturation to output precision and a saturating overflow-beat counter.
module p_int_div_pow2_pipe #(
  parameter int LANES     = 4,
  parameter int I_PREC    = 16,
  parameter int O_PREC    = 8,
  parameter int SIGN      = 1,
  parameter int MAX_SHIFT = 8,
  parameter int CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset_,
  p_int_div_pow2_pipe_if.slave     bus,
  input  logic                     clr_cnt,
  output logic [CNT_W-1:0]         ovf_cnt
);
  localparam int SW = $clog2(MAX_SHIFT + 1);

  localparam logic [I_PREC:0]   S_MAX  = (I_PREC+1)'((1 << (O_PREC - 1)) - 1);
  localparam logic [I_PREC:0]   S_MIN  = ~S_MAX;
  localparam logic [I_PREC:0]   U_MAX  = (I_PREC+1)'((1 << O_PREC) - 1);
  localparam logic [O_PREC-1:0] HI_VAL = (SIGN != 0) ? {1'b0, {(O_PREC-1){1'b1}}} : {O_PREC{1'b1}};
  localparam logic [O_PREC-1:0] LO_VAL = (SIGN != 0) ? {1'b1, {(O_PREC-1){1'b0}}} : {O_PREC{1'b0}};

  logic                              s1_valid, s2_valid;
  logic [LANES-1:0][I_PREC:0]        s1_sum, sum_d;
  logic [LANES-1:0][MAX_SHIFT-1:0]   s1_rem, rem_d, s2_rem;
  logic [LANES-1:0][O_PREC-1:0]      s2_data, clamp_d;
  logic [LANES-1:0]                  s2_ovf, ovf_d;
  logic [SW-1:0]                     n_eff;
  logic                              s1_adv, s2_adv, in_fire, out_fire;

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_fire  = bus.in_valid && s1_adv;
  assign out_fire = s2_valid && bus.out_ready;

  assign n_eff = (bus.in_shift > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : bus.in_shift;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [I_PREC-1:0] x, mask, low;
    logic [I_PREC:0]   xe, q;
    logic              half, sticky, carry, ovf_hi, ovf_lo;

    assign x      = bus.in_data[g*I_PREC +: I_PREC];
    assign xe     = (SIGN != 0) ? {x[I_PREC-1], x} : {1'b0, x};
    assign q      = $unsigned($signed(xe) >>> n_eff);
    assign mask   = ~({I_PREC{1'b1}} << n_eff);
    assign low    = x & mask;
    // Bit n-1 is the only bit kept by mask but dropped by mask>>1; zero when n=0.
    assign half   = |(low & ~(mask >> 1));
    assign sticky = |low;
    assign carry  = (bus.in_mode == 2'd1) ? half :
                    (bus.in_mode == 2'd2) ? sticky : 1'b0;
    assign sum_d[g] = q + {{I_PREC{1'b0}}, carry};
    assign rem_d[g] = low[MAX_SHIFT-1:0];

    assign ovf_hi = (SIGN != 0) ? ($signed(s1_sum[g]) > $signed(S_MAX)) : (s1_sum[g] > U_MAX);
    assign ovf_lo = (SIGN != 0) ? ($signed(s1_sum[g]) < $signed(S_MIN)) : 1'b0;
    assign ovf_d[g]   = ovf_hi || ovf_lo;
    assign clamp_d[g] = ovf_hi ? HI_VAL : ovf_lo ? LO_VAL : s1_sum[g][O_PREC-1:0];
  end

  // Stage 1 captures the rounded quotient only on an accepted beat.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_rem   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_sum <= sum_d;
        s1_rem <= rem_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_rem   <= '0;
      s2_ovf   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= clamp_d;
        s2_rem  <= s1_rem;
        s2_ovf  <= ovf_d;
      end
    end
  end

  // Clear takes priority; a coincident overflow event is intentionally lost.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      ovf_cnt <= '0;
    end else if (clr_cnt) begin
      ovf_cnt <= '0;
    end else if (out_fire && (|s2_ovf) && (ovf_cnt != {CNT_W{1'b1}})) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_rem   = s2_rem;
  assign bus.out_ovf   = s2_ovf;
endmodule

// File: tb/tb_p_int_div_pow2_pipe.sv
// Directed bench for p_int_div_pow2_pipe: rounding modes, saturation, shift clamp,
// stall behaviour, counter saturation/clear and asynchronous reset.
module tb_p_int_div_pow2_pipe;
  localparam int LANES     = 4;
  localparam int I_PREC    = 16;
  localparam int O_PREC    = 8;
  localparam int SIGN      = 1;
  localparam int MAX_SHIFT = 8;
  localparam int CNT_W     = 2;

  logic             clk = 1'b0;
  logic             reset_;
  logic             clr_cnt;
  logic [CNT_W-1:0] ovf_cnt;
  int               test_cnt = 0;
  int               fail_cnt = 0;

  p_int_div_pow2_pipe_if #(
    .LANES(LANES), .I_PREC(I_PREC), .O_PREC(O_PREC), .MAX_SHIFT(MAX_SHIFT)
  ) bus ();

  p_int_div_pow2_pipe #(
    .LANES(LANES), .I_PREC(I_PREC), .O_PREC(O_PREC), .SIGN(SIGN),
    .MAX_SHIFT(MAX_SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .reset_  (reset_),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .ovf_cnt (ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic [31:0] rem,
                            input logic [3:0] ovf);
    check_output({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check_output({tag, "_data"},  64'(bus.out_data),  64'(data));
    check_output({tag, "_rem"},   64'(bus.out_rem),   64'(rem));
    check_output({tag, "_ovf"},   64'(bus.out_ovf),   64'(ovf));
  endtask

  // One beat into an otherwise idle pipe; returns with the beat on the output.
  // Shift/mode/data are scrambled after acceptance to show they are sampled on transfer.
  task automatic apply_stimulus(input logic [63:0] data, input logic [3:0] shift, input logic [1:0] mode);
    bus.in_data   = data;
    bus.in_shift  = shift;
    bus.in_mode   = mode;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_output("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 64'h1234_5678_9ABC_DEF0;
    bus.in_shift = 4'd0;
    bus.in_mode  = 2'd3;
    tick();
  endtask

  initial begin : main
    int sent, rcvd, in_flight, first_acc, first_out;
    logic prev_stall;
    logic [31:0] prev_data;

    reset_        = 1'b0;
    clr_cnt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shift  = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b1;

    #12;
    check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_out_data",  64'(bus.out_data),  64'd0);
    check_output("rst_out_rem",   64'(bus.out_rem),   64'd0);
    check_output("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
    check_output("rst_ovf_cnt",   64'(ovf_cnt),       64'd0);
    @(posedge clk);
    #3 reset_ = 1'b1;
    tick();
    check_output("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Lanes: -7, 5, 16, -256 with n=1 under each rounding mode.
    apply_stimulus(64'hFF00_0010_0005_FFF9, 4'd1, 2'd0);
    check_beat("m0_n1", 32'h800802FC, 32'h00000101, 4'h0);
    apply_stimulus(64'hFF00_0010_0005_FFF9, 4'd1, 2'd1);
    check_beat("m1_n1", 32'h800803FD, 32'h00000101, 4'h0);
    apply_stimulus(64'hFF00_0010_0005_FFF9, 4'd1, 2'd2);
    check_beat("m2_n1", 32'h800803FD, 32'h00000101, 4'h0);
    apply_stimulus(64'hFF00_0010_0005_FFF9, 4'd1, 2'd3);
    check_beat("m3_n1", 32'h800802FC, 32'h00000101, 4'h0);

    // Lanes: 1000, -1024, 515, -509 with n=2 floor: three saturate.
    apply_stimulus(64'hFE03_0203_FC00_03E8, 4'd2, 2'd0);
    check_output("cnt_before_ovf", 64'(ovf_cnt), 64'd0);
    check_beat("sat_n2", 32'h807F807F, 32'h03030000, 4'h7);
    tick();
    check_output("cnt_after_ovf", 64'(ovf_cnt), 64'd1);

    apply_stimulus(64'h0000_0000_0000_7FFF, 4'd1, 2'd1);
    check_beat("nowrap_n1", 32'h0000007F, 32'h00000001, 4'h1);
    apply_stimulus(64'h0000_FF85_0005_7FFF, 4'd0, 2'd2);
    check_beat("pass_n0", 32'h0085057F, 32'h00000000, 4'h1);

    // in_shift=15 behaves as 8.
    apply_stimulus(64'hFFFF_8000_0381_0300, 4'd15, 2'd2);
    check_beat("clamp_shift", 32'h00800403, 32'hFF008100, 4'h0);
    check_output("cnt_three", 64'(ovf_cnt), 64'd3);

    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check_output("cnt_clear", 64'(ovf_cnt), 64'd0);
    check_output("drained", 64'(bus.out_valid), 64'd0);

    // Streaming with a three-cycle downstream stall.
    sent = 0; rcvd = 0; in_flight = 0; first_acc = -1; first_out = -1;
    prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 40 && rcvd < 8; c++) begin
      bus.in_valid  = (sent < 8);
      bus.in_data   = {4{16'(sent * 4 + 1)}};
      bus.in_shift  = 4'd2;
      bus.in_mode   = 2'd0;
      bus.out_ready = !(c >= 3 && c <= 5);
      #1;
      check_output("stream_in_ready", 64'(bus.in_ready), 64'((in_flight < 2) || bus.out_ready));
      if (prev_stall) begin
        check_output("stall_valid", 64'(bus.out_valid), 64'd1);
        check_output("stall_data",  64'(bus.out_data),  64'(prev_data));
      end
      if (bus.out_valid) begin
        if (first_out < 0) first_out = c;
        check_output("stream_data", 64'(bus.out_data), 64'({4{8'(rcvd)}}));
        check_output("stream_rem",  64'(bus.out_rem),  64'h01010101);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (first_acc < 0) first_acc = c;
        sent++;
        in_flight++;
      end
      if (bus.out_valid && bus.out_ready) begin
        rcvd++;
        in_flight--;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check_output("stream_count", 64'(rcvd), 64'd8);
    check_output("stream_latency", 64'(first_out - first_acc), 64'd2);

    // Six overflow beats: counter pins at 3, then clear beats the sixth.
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(64'h0000_0000_0000_7FFF, 4'd0, 2'd0);
      check_beat("ovf_beat", 32'h0000007F, 32'h00000000, 4'h1);
    end
    check_output("cnt_saturated", 64'(ovf_cnt), 64'd3);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check_output("clr_wins", 64'(ovf_cnt), 64'd0);

    // Asynchronous reset with beats in flight.
    bus.in_data  = 64'h0000_0000_0000_7FFF;
    bus.in_shift = 4'd0;
    bus.in_mode  = 2'd0;
    bus.in_valid = 1'b1;
    repeat (4) tick();
    check_output("pre_rst_cnt",   64'(ovf_cnt),       64'd2);
    check_output("pre_rst_valid", 64'(bus.out_valid), 64'd1);
    #3 reset_ = 1'b0;
    #1;
    check_output("async_rst_valid", 64'(bus.out_valid), 64'd0);
    check_output("async_rst_cnt",   64'(ovf_cnt),       64'd0);
    check_output("async_rst_ovf",   64'(bus.out_ovf),   64'd0);
    bus.in_valid = 1'b0;
    tick();
    #3 reset_ = 1'b1;
    tick();
    tick();
    check_output("dropped_valid", 64'(bus.out_valid), 64'd0);
    check_output("dropped_ready", 64'(bus.in_ready),  64'd1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule
